// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port-1 read streamer: default geometry and FSM states.
package sram_pkg;

   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 32;
   localparam int BYTES_PER_WORD = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      SEND,
      DONE
   } state_t;

endpackage

// File: rtl/sram_port1_streamer_if.sv
// Byte-stream output and SRAM read-port bundle of the port-1 streamer.
interface sram_port1_streamer_if #(
   parameter int ADDR_W = sram_pkg::ADDR_W,
   parameter int DATA_W = sram_pkg::DATA_W
);

   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              sram_csb1;
   logic [ADDR_W-1:0] sram_addr1;
   logic [DATA_W-1:0] sram_dout1;

   // Streamer side: drives the byte stream and the SRAM read request.
   modport master (
      output tx_data, tx_valid, sram_csb1, sram_addr1,
      input  tx_ready, sram_dout1
   );

   // Consumer/SRAM side.
   modport slave (
      input  tx_data, tx_valid, sram_csb1, sram_addr1,
      output tx_ready, sram_dout1
   );

endinterface

// File: rtl/sram_word_serializer.sv
// Holds one SRAM word and emits it least-significant byte first over valid/ready.
module sram_word_serializer
   import sram_pkg::*;
#(
   parameter int DATA_W = sram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              last
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q;
   logic              valid_q;

   // Byte select comes straight from registers, so tx_data holds while stalled.
   assign tx_data  = word_q[{idx_q, 3'b000} +: 8];
   assign tx_valid = valid_q;
   assign last     = (idx_q == IDX_W'(NBYTES - 1));

   // NOTE: registers are written with <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= load_data;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && tx_ready) begin
         if (last) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/sram_port1_streamer.sv
// Reads a run of consecutive words from SRAM port 1 and streams them out LSB-first.
// Define SRAM_RD_PREFETCH_EN to overlap the next word's read with the current word's bytes.
module sram_port1_streamer #(
   parameter int ADDR_W = sram_pkg::ADDR_W,
   parameter int DATA_W = sram_pkg::DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [ADDR_W:0]       len,
   output logic                  busy,
   output logic                  done,
   sram_port1_streamer_if.master bus
);

   import sram_pkg::*;

   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] REM_TWO = (ADDR_W + 1)'(2);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr1_q;
   logic [ADDR_W:0]   remaining_q;
   logic              csb1_q;
   logic              busy_q;
   logic              done_q;

   logic              ser_load;
   logic [DATA_W-1:0] ser_word;
   logic [7:0]        ser_data;
   logic              ser_valid;
   logic              ser_last;
   logic              fire_last;
   logic              last_word;

   assign fire_last = ser_valid && bus.tx_ready && ser_last;
   assign last_word = (remaining_q == REM_ONE);

`ifdef SRAM_RD_PREFETCH_EN
   logic [DATA_W-1:0] pf_word_q;
   logic              pf_capture_q;

   // The next word is swapped in on the same edge the last byte leaves, so no bubble.
   assign ser_load = (state_q == WAIT) || ((state_q == SEND) && fire_last && !last_word);
   assign ser_word = (state_q == WAIT) ? bus.sram_dout1 : pf_word_q;

   // NOTE: pure data register, always written before it is read, so it carries no reset.
   always_ff @(posedge clk) begin
      if (pf_capture_q) pf_word_q <= bus.sram_dout1;
   end
`else
   assign ser_load = (state_q == WAIT);
   assign ser_word = bus.sram_dout1;
`endif

   sram_word_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ser_load),
      .load_data (ser_word),
      .tx_data   (ser_data),
      .tx_valid  (ser_valid),
      .tx_ready  (bus.tx_ready),
      .last      (ser_last)
   );

   assign bus.tx_data    = ser_data;
   assign bus.tx_valid   = ser_valid;
   assign bus.sram_csb1  = csb1_q;
   assign bus.sram_addr1 = addr1_q;
   assign busy           = busy_q;
   assign done           = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         addr1_q     <= '0;
         remaining_q <= '0;
         csb1_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SRAM_RD_PREFETCH_EN
         pf_capture_q <= 1'b0;
`endif
      end else begin
`ifdef SRAM_RD_PREFETCH_EN
         pf_capture_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     addr_q      <= start_addr;
                     remaining_q <= len;
                     csb1_q      <= 1'b0;
                     addr1_q     <= start_addr;
                     busy_q      <= 1'b1;
                     state_q     <= FETCH;
                  end
               end
            end
            FETCH: begin
               csb1_q  <= 1'b1;
               state_q <= WAIT;
            end
            WAIT: begin
               state_q <= SEND;
`ifdef SRAM_RD_PREFETCH_EN
               if (remaining_q > REM_ONE) begin
                  csb1_q  <= 1'b0;
                  addr1_q <= addr_q + ADDR_W'(1);
               end
`endif
            end
            SEND: begin
`ifdef SRAM_RD_PREFETCH_EN
               // A prefetch holds csb1 low for exactly one cycle; data arrives one edge later.
               if (!csb1_q) begin
                  csb1_q       <= 1'b1;
                  pf_capture_q <= 1'b1;
               end
`endif
               if (fire_last) begin
                  remaining_q <= remaining_q - REM_ONE;
                  addr_q      <= addr_q + ADDR_W'(1);
                  if (last_word) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
`ifdef SRAM_RD_PREFETCH_EN
                  else if (remaining_q > REM_TWO) begin
                     csb1_q  <= 1'b0;
                     addr1_q <= addr_q + ADDR_W'(2);
                  end
`else
                  else begin
                     csb1_q  <= 1'b0;
                     addr1_q <= addr_q + ADDR_W'(1);
                     state_q <= FETCH;
                  end
`endif
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
